// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: sequencer for one matrix-multiply job.
// Latches the job dimensions, clears the A/B write-address generators,
// routes the shared element stream into the A banks and then the B banks,
// kicks the systolic array and reports completion.
module mm_seq_ctrl #(
   parameter int N1           = 4,
   parameter int N2           = 4,
   parameter int MATRIXSIZE_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [MATRIXSIZE_W-1:0] M1dN1,
   input  logic [MATRIXSIZE_W-1:0] M2,
   input  logic [MATRIXSIZE_W-1:0] M3dN2,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic                    valid_A,
   output logic                    valid_B,
   output logic                    wr_clr,
   output logic                    compute_start,
   input  logic                    compute_done,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err
);

   // Counter width covers the larger of the two scaled limits so that
   // M1dN1*N1 and M3dN2*N2 are never truncated.
   localparam int AW = MATRIXSIZE_W + $clog2(N1);
   localparam int BW = MATRIXSIZE_W + $clog2(N2);
   localparam int CW = (AW > BW) ? AW : BW;

   typedef enum logic [2:0] {
      IDLE, CLR, LOAD_A, LOAD_B, COMPUTE, WAIT, DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [MATRIXSIZE_W-1:0] m1_q, m1_d;
   logic [MATRIXSIZE_W-1:0] m2_q, m2_d;
   logic [MATRIXSIZE_W-1:0] m3_q, m3_d;
   logic [CW-1:0]           col_q, col_d;
   logic [CW-1:0]           row_q, row_d;
   logic                    cfg_err_q, cfg_err_d;

   logic [CW-1:0] a_col_last, a_row_last, b_col_last, b_row_last;
   logic          beat;
   logic          dim_zero;

   // Last counter values; dimensions are guaranteed non-zero while loading.
   assign a_col_last = CW'(m2_q) - CW'(1);
   assign a_row_last = CW'(m1_q) * CW'(N1) - CW'(1);
   assign b_col_last = CW'(m3_q) * CW'(N2) - CW'(1);
   assign b_row_last = CW'(m2_q) - CW'(1);

   assign s_ready       = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign beat          = s_valid & s_ready;
   assign valid_A       = beat & (state_q == LOAD_A);
   assign valid_B       = beat & (state_q == LOAD_B);
   assign wr_clr        = (state_q == CLR);
   assign compute_start = (state_q == COMPUTE);
   assign done          = (state_q == DONE);
   assign busy          = (state_q != IDLE);
   assign cfg_err       = cfg_err_q;

   assign dim_zero = (M1dN1 == '0) || (M2 == '0) || (M3dN2 == '0);

   // State, latched dimensions, beat counters and the config-error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m1_q      <= '0;
         m2_q      <= '0;
         m3_q      <= '0;
         col_q     <= '0;
         row_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         m1_q      <= m1_d;
         m2_q      <= m2_d;
         m3_q      <= m3_d;
         col_q     <= col_d;
         row_q     <= row_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Next-state logic: job acceptance, nested beat counting, compute handshake.
   always_comb begin
      state_d   = state_q;
      m1_d      = m1_q;
      m2_d      = m2_q;
      m3_d      = m3_q;
      col_d     = col_q;
      row_d     = row_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (dim_zero) begin
                  cfg_err_d = 1'b1;
               end else begin
                  m1_d    = M1dN1;
                  m2_d    = M2;
                  m3_d    = M3dN2;
                  state_d = CLR;
               end
            end
         end
         CLR: begin
            col_d   = '0;
            row_d   = '0;
            state_d = LOAD_A;
         end
         LOAD_A: begin
            if (beat) begin
               if (col_q == a_col_last) begin
                  col_d = '0;
                  if (row_q == a_row_last) begin
                     row_d   = '0;
                     state_d = LOAD_B;
                  end else begin
                     row_d = row_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         LOAD_B: begin
            if (beat) begin
               if (col_q == b_col_last) begin
                  col_d = '0;
                  if (row_q == b_row_last) begin
                     row_d   = '0;
                     state_d = COMPUTE;
                  end else begin
                     row_d = row_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         COMPUTE: begin
            // A completion in the kick cycle itself skips WAIT.
            state_d = compute_done ? DONE : WAIT;
         end
         WAIT: begin
            if (compute_done) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Top-level sequencer for one matrix-multiply job on the IBERT accelerator. Accepts a start command with matrix dimensions, clears the A/B bank write-address generators, then steers one shared input element stream first into the A banks (`valid_A`) and then into the B banks (`valid_B`). It then kicks the systolic array, waits for its completion and reports done. It sits between the host/DMA stream and the A/B write-address generators and the compute core.

## Interface
- `N1`, 4: systolic rows (A banks).
- `N2`, 4: systolic columns (B banks).
- `MATRIXSIZE_W`, 16: width of dimension fields.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  job request; honoured only in IDLE.
- `M1dN1`  in  MATRIXSIZE_W  A rows / N1; sampled on accepted start.
- `M2`  in  MATRIXSIZE_W  shared (inner) dimension; sampled on accepted start.
- `M3dN2`  in  MATRIXSIZE_W  B columns / N2; sampled on accepted start.
- `s_valid`  in  1  input element stream valid.
- `s_ready`  out  1  stream ready (combinational from state).
- `valid_A`  out  1  element accepted into A writer: `s_valid & s_ready & (state==LOAD_A)`.
- `valid_B`  out  1  element accepted into B writer: `s_valid & s_ready & (state==LOAD_B)`.
- `wr_clr`  out  1  one-cycle synchronous clear to both write-address generators.
- `compute_start`  out  1  one-cycle pulse to the compute core.
- `compute_done`  in  1  compute core completion pulse.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle job-complete pulse.
- `cfg_err`  out  1  one-cycle pulse when start is rejected for a zero dimension.

## Operation
- States: IDLE, CLR, LOAD_A, LOAD_B, COMPUTE, WAIT, DONE.
- IDLE: on `start` with all three dimensions non-zero, latch them and go to CLR. If any dimension is zero, pulse `cfg_err` next cycle and stay in IDLE. `start` in any other state is ignored.
- CLR: `wr_clr`=1 for exactly this cycle. Clear both beat counters. Go to LOAD_A.
- LOAD_A: `s_ready`=1. Nested counters advance only on accepted beats:
  - inner `col` runs 0..M2-1;
  - outer `row` runs 0..M1dN1*N1-1.
  - The outer limit is computed at width MATRIXSIZE_W+$clog2(N1), with no truncation.
  - On the accepted beat with `col`=M2-1 and `row`=last: clear counters and go to LOAD_B.
- LOAD_B: `s_ready`=1. Inner `col` runs 0..M3dN2*N2-1 (width MATRIXSIZE_W+$clog2(N2)); outer `row` runs 0..M2-1. On the last accepted beat, go to COMPUTE.
- COMPUTE: `compute_start`=1 for this single cycle. Go to WAIT, or go directly to DONE if `compute_done` is already high this cycle.
- WAIT: hold until `compute_done`=1, then go to DONE. `compute_done` is ignored in all other states.
- DONE: `done`=1 for one cycle. Return to IDLE; a new `start` is accepted from the following cycle.
- `s_valid` low stalls counters; no timeout.
- Latched dimensions stay constant for the whole job; input changes mid-job have no effect.

## Timing
- Reset (asynchronous, immediate, including mid-job): state=IDLE, counters=0, latched dimensions=0.
  - Outputs: `s_ready`=0, `valid_A`=0, `valid_B`=0, `wr_clr`=0, `compute_start`=0, `busy`=0, `done`=0, `cfg_err`=0.
  - The writers are re-cleared by the next job's CLR.
- `wr_clr`, `compute_start`, `done` and `cfg_err` are registered state decodes, so each is a single-cycle pulse.
- `s_ready`, `valid_A` and `valid_B` are combinational; there is zero-cycle latency from `s_valid`.
- Accepted start at edge t: CLR during cycle t+1 (`busy`=1, `wr_clr`=1). LOAD_A from t+2, so the first A beat can be accepted at t+2.
- Last A beat at cycle k: LOAD_B from k+1. There is no bubble and no beat is lost or duplicated at the switch.
- Last B beat at cycle j: `compute_start` in cycle j+1; WAIT from j+2.
- `compute_done` at cycle w (in COMPUTE or WAIT): `done` in cycle w+1; IDLE (`busy`=0) at w+2.
- Minimum job length, with s_valid held high: 2 + A_beats + B_beats + 2 cycles to `done`.

## Test plan
- Basic job: N1=N2=4, M1dN1=1, M2=2, M3dN2=1, `s_valid` held high → `wr_clr` at t+1.
  - Exactly 8 `valid_A` pulses (t+2..t+9), then 8 `valid_B` pulses (t+10..t+17).
  - `compute_start` at t+18; with `compute_done` at t+21, `done` at t+22 and `busy`=0 at t+23.
- Backpressure gaps: same config with `s_valid` toggling 1,0,1,0 → still exactly 8 A and 8 B acceptances. Counters freeze during gaps; the A→B switch happens after the 8th A acceptance.
- Zero dimension: start with M2=0 → `cfg_err`=1 for one cycle, `busy` stays 0, no `wr_clr` and no `s_ready`.
- Start and `compute_done` filtering: pulse `start` during LOAD_B and `compute_done` during LOAD_A → both are ignored; beat counts and the sequence are unchanged.
- Reset mid-job: assert `rst_n`=0 during LOAD_A after 3 beats → all outputs go to 0 immediately. After release, a new start with M1dN1=2, M2=1, M3dN2=2 produces 8 A beats and 8 B beats.
- Same-cycle completion: `compute_done`=1 in the COMPUTE cycle → `done` in the next cycle; WAIT is skipped.
